pcie_tx_arbiter: RTL and testbench

PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

---
 rtl/pcie_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter: two-source TLP arbiter for a PCIe core TX local-link port.
// Source 0 (completer) and source 1 (posted writer) are granted whole TLPs with
// alternating priority. The granted source is passed straight through to the core,
// so the only state kept here is the grant, a beat counter and the status counters.
module pcie_tx_arbiter #(
    parameter int unsigned MAX_BEATS = 32
) (
    input  logic        clk,
    input  logic        reset,
    // source 0: completer
    input  logic [63:0] s0_data,
    input  logic        s0_sof,
    input  logic        s0_eof,
    input  logic        s0_half,
    input  logic        s0_valid,
    output logic        s0_ready,
    // source 1: posted writer
    input  logic [63:0] s1_data,
    input  logic        s1_sof,
    input  logic        s1_eof,
    input  logic        s1_half,
    input  logic        s1_valid,
    output logic        s1_ready,
    // core TX local-link (active-low controls)
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [3:0]  trn_tbuf_av,
    // status
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        proto_err,
    output logic        busy
);

    // Wide enough to hold MAX_BEATS itself.
    localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    state_e           state_q;
    logic             last_served_q;
    logic [BeatW-1:0] beat_cnt_q;
    logic [15:0]      pkt_cnt0_q;
    logic [15:0]      pkt_cnt1_q;
    logic             proto_err_q;
    logic             dsc_q;

    // Muxed view of the granted source.
    logic [63:0] sel_data;
    logic        sel_sof;
    logic        sel_eof;
    logic        sel_half;
    logic        sel_valid;
    logic        granted;

    // Arbitration helpers, only meaningful in StIdle.
    logic cand0;
    logic cand1;
    logic pick1;
    logic stray;
    logic accept;

    // Select the granted source; nothing is selected while idle.
    always_comb begin
        sel_data  = 64'h0;
        sel_sof   = 1'b0;
        sel_eof   = 1'b0;
        sel_half  = 1'b0;
        sel_valid = 1'b0;
        case (state_q)
            StGnt0: begin
                sel_data  = s0_data;
                sel_sof   = s0_sof;
                sel_eof   = s0_eof;
                sel_half  = s0_half;
                sel_valid = s0_valid;
            end
            StGnt1: begin
                sel_data  = s1_data;
                sel_sof   = s1_sof;
                sel_eof   = s1_eof;
                sel_half  = s1_half;
                sel_valid = s1_valid;
            end
            default: ;
        endcase
    end

    // Local-link pass-through and per-source ready.
    always_comb begin
        granted        = (state_q != StIdle);
        trn_td         = sel_data;
        trn_tsof_n     = ~sel_sof;
        trn_teof_n     = ~sel_eof;
        trn_tsrc_rdy_n = ~sel_valid;
        // Only the upper DW is valid on a half-width eof beat.
        trn_trem_n     = (sel_eof && sel_half) ? 8'h0F : 8'h00;
        trn_tsrc_dsc_n = ~dsc_q;
        s0_ready       = (state_q == StGnt0) && !trn_tdst_rdy_n;
        s1_ready       = (state_q == StGnt1) && !trn_tdst_rdy_n;
        accept         = granted && sel_valid && !trn_tdst_rdy_n;
        busy           = granted;
        pkt_cnt0       = pkt_cnt0_q;
        pkt_cnt1       = pkt_cnt1_q;
        proto_err      = proto_err_q;
    end

    // Candidate selection: a source competes only when presenting a valid sof beat.
    always_comb begin
        cand0 = s0_valid && s0_sof;
        cand1 = s1_valid && s1_sof;
        // On a tie the source not served last wins.
        pick1 = cand1 && (!cand0 || !last_served_q);
        stray = (s0_valid && !s0_sof) || (s1_valid && !s1_sof);
    end

    // Grant FSM, beat counter, packet counters and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            last_served_q <= 1'b1;
            beat_cnt_q    <= '0;
            pkt_cnt0_q    <= 16'h0;
            pkt_cnt1_q    <= 16'h0;
            proto_err_q   <= 1'b0;
            dsc_q         <= 1'b0;
        end else begin
            dsc_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A mid-packet beat with no grant is left unconsumed and flagged.
                    if (stray) begin
                        proto_err_q <= 1'b1;
                    end
                    // Buffer availability gates only the grant decision.
                    if ((cand0 || cand1) && (trn_tbuf_av != 4'h0)) begin
                        state_q    <= pick1 ? StGnt1 : StGnt0;
                        beat_cnt_q <= '0;
                    end
                end
                StGnt0, StGnt1: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        // A second sof inside a packet is forwarded but flagged.
                        if (sel_sof && (beat_cnt_q != '0)) begin
                            proto_err_q <= 1'b1;
                        end
                        if (sel_eof) begin
                            state_q       <= StIdle;
                            last_served_q <= (state_q == StGnt1);
                            if (state_q == StGnt0) begin
                                pkt_cnt0_q <= pkt_cnt0_q + 16'h1;
                            end else begin
                                pkt_cnt1_q <= pkt_cnt1_q + 16'h1;
                            end
                        end else if (beat_cnt_q == LastBeat) begin
                            // Runaway packet: discard toward the core and drop the grant.
                            proto_err_q <= 1'b1;
                            dsc_q       <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb_pcie_tx_arbiter: scenario tasks for the two-source TLP arbiter. Packet traffic
// is checked against a packet-level round-robin model built from the source queues.
module tb_pcie_tx_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic        sof;
        logic        eof;
        logic        half;
    } beat_t;

    typedef struct packed {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic [7:0]  trem_n;
        logic        src;
    } link_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] s0_data, s1_data;
    logic        s0_sof, s0_eof, s0_half, s0_valid, s0_ready;
    logic        s1_sof, s1_eof, s1_half, s1_valid, s1_ready;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic [3:0]  trn_tbuf_av;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic        proto_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t q0[$], q1[$], exp0[$], exp1[$];
    int    len0[$], len1[$];
    link_t link_log[$], exp_link[$];
    int    link_cyc[$], dsc_log[$];
    logic  err_log[$];
    int    npkt = 0;

    always #5 clk = ~clk;

    pcie_tx_arbiter #(.MAX_BEATS(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .s0_data        (s0_data),
        .s0_sof         (s0_sof),
        .s0_eof         (s0_eof),
        .s0_half        (s0_half),
        .s0_valid       (s0_valid),
        .s0_ready       (s0_ready),
        .s1_data        (s1_data),
        .s1_sof         (s1_sof),
        .s1_eof         (s1_eof),
        .s1_half        (s1_half),
        .s1_valid       (s1_valid),
        .s1_ready       (s1_ready),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .trn_tbuf_av    (trn_tbuf_av),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .proto_err      (proto_err),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        s0_data = 64'h0; s0_sof = 1'b0; s0_eof = 1'b0; s0_half = 1'b0; s0_valid = 1'b0;
        s1_data = 64'h0; s1_sof = 1'b0; s1_eof = 1'b0; s1_half = 1'b0; s1_valid = 1'b0;
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        len0.delete(); len1.delete(); link_log.delete(); exp_link.delete();
        link_cyc.delete(); dsc_log.delete(); err_log.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_src();
        trn_tdst_rdy_n = 1'b0;
        trn_tbuf_av    = 4'hF;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Queue one TLP on a source; half is set on every beat so only eof may honour it.
    task automatic add_pkt(input int s, input int len, input bit half);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {4'(s), 12'(npkt), 16'(k), $urandom()};
            b.sof  = (k == 0);
            b.eof  = (k == len - 1);
            b.half = half;
            if (s == 0) begin q0.push_back(b); exp0.push_back(b); end
            else        begin q1.push_back(b); exp1.push_back(b); end
        end
        if (s == 0) len0.push_back(len); else len1.push_back(len);
        npkt++;
    endtask

    function automatic link_t to_link(input beat_t b, input logic src);
        link_t l;
        l.td     = b.data;
        l.sof_n  = ~b.sof;
        l.eof_n  = ~b.eof;
        l.trem_n = (b.eof && b.half) ? 8'h0F : 8'h00;
        l.src    = src;
        return l;
    endfunction

    // Reference model: whole packets, alternating whenever both sources have one waiting.
    task automatic build_model();
        int p0, p1, i0, i1, pick, last;
        p0 = 0; p1 = 0; i0 = 0; i1 = 0; last = 1;
        exp_link.delete();
        while (p0 < len0.size() || p1 < len1.size()) begin
            if (p0 < len0.size() && p1 < len1.size()) pick = 1 - last;
            else pick = (p0 < len0.size()) ? 0 : 1;
            if (pick == 0) begin
                for (int k = 0; k < len0[p0]; k++) begin
                    exp_link.push_back(to_link(exp0[i0], 1'b0)); i0++;
                end
                p0++;
            end else begin
                for (int k = 0; k < len1[p1]; k++) begin
                    exp_link.push_back(to_link(exp1[i1], 1'b1)); i1++;
                end
                p1++;
            end
            last = pick;
        end
    endtask

    // Source drivers plus link monitor. Sof beats are always presented valid; later
    // beats are gapped with probability gap_pct, the core stalls with stall_pct.
    task automatic drive(input int max_cyc, input int gap_pct, input int stall_pct,
                         output bit timed_out);
        int    cyc;
        bit    f0, f1;
        beat_t b;
        link_t l;
        cyc = 0;
        while (cyc < max_cyc && (q0.size() != 0 || q1.size() != 0)) begin
            if (q0.size() != 0) begin
                b = q0[0];
                s0_data = b.data; s0_sof = b.sof; s0_eof = b.eof; s0_half = b.half;
                s0_valid = b.sof || (int'($urandom_range(99)) >= gap_pct);
            end else begin
                s0_valid = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0;
            end
            if (q1.size() != 0) begin
                b = q1[0];
                s1_data = b.data; s1_sof = b.sof; s1_eof = b.eof; s1_half = b.half;
                s1_valid = b.sof || (int'($urandom_range(99)) >= gap_pct);
            end else begin
                s1_valid = 1'b0; s1_sof = 1'b0; s1_eof = 1'b0;
            end
            trn_tdst_rdy_n = (int'($urandom_range(99)) < stall_pct);
            #1;
            if (!trn_tsrc_dsc_n) dsc_log.push_back(cyc);
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                l.td = trn_td; l.sof_n = trn_tsof_n; l.eof_n = trn_teof_n;
                l.trem_n = trn_trem_n; l.src = s1_ready;
                link_log.push_back(l);
                link_cyc.push_back(cyc);
                err_log.push_back(proto_err);
            end
            f0 = s0_valid && s0_ready;
            f1 = s1_valid && s1_ready;
            tick();
            if (f0) void'(q0.pop_front());
            if (f1) void'(q1.pop_front());
            cyc++;
        end
        timed_out = (q0.size() != 0 || q1.size() != 0);
        clear_src();
        trn_tdst_rdy_n = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s0_valid = 1'b1; s0_sof = 1'b1; s1_valid = 1'b1; s1_sof = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_n: got %b want 1", trn_tsrc_rdy_n); end
        n_checks++; if (trn_tsof_n !== 1'b1) begin n_fail++; $display("FAIL reset_sof_n: got %b want 1", trn_tsof_n); end
        n_checks++; if (trn_teof_n !== 1'b1) begin n_fail++; $display("FAIL reset_eof_n: got %b want 1", trn_teof_n); end
        n_checks++; if (trn_tsrc_dsc_n !== 1'b1) begin n_fail++; $display("FAIL reset_dsc_n: got %b want 1", trn_tsrc_dsc_n); end
        n_checks++; if (trn_trem_n !== 8'h00) begin n_fail++; $display("FAIL reset_trem: got %h want 00", trn_trem_n); end
        n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_ready: got %b want 0", s0_ready); end
        n_checks++; if (s1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s1_ready: got %b want 0", s1_ready); end
        n_checks++; if (pkt_cnt0 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", pkt_cnt0); end
        n_checks++; if (pkt_cnt1 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", pkt_cnt1); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", proto_err); end
        clear_src();
        reset = 1'b0;
    endtask

    task automatic test_single_tlp();
        logic [63:0] hdr, dat;
        apply_reset();
        hdr = 64'h4A00_0001_0000_0004;
        dat = 64'h0123_4567_89AB_CDEF;
        s0_data = hdr; s0_sof = 1'b1; s0_eof = 1'b0; s0_valid = 1'b1;
        #1;
        n_checks++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL single_idle_rdy_n: got %b want 1", trn_tsrc_rdy_n); end
        tick();
        n_checks++; if (trn_td !== hdr) begin n_fail++; $display("FAIL single_hdr: got %h want %h", trn_td, hdr); end
        n_checks++; if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} !== 3'b010) begin n_fail++; $display("FAIL single_b1_ctl: got %b want 010", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}); end
        n_checks++; if ({s0_ready, s1_ready, busy} !== 3'b101) begin n_fail++; $display("FAIL single_b1_rdy: got %b want 101", {s0_ready, s1_ready, busy}); end
        tick();
        s0_data = dat; s0_sof = 1'b0; s0_eof = 1'b1;
        #1;
        n_checks++; if (trn_td !== dat) begin n_fail++; $display("FAIL single_dat: got %h want %h", trn_td, dat); end
        n_checks++; if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} !== 3'b100) begin n_fail++; $display("FAIL single_b2_ctl: got %b want 100", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}); end
        n_checks++; if (trn_trem_n !== 8'h00) begin n_fail++; $display("FAIL single_trem: got %h want 00", trn_trem_n); end
        tick();
        clear_src();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got busy %b want 0", busy); end
        n_checks++; if (pkt_cnt0 !== 16'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d want 1", pkt_cnt0); end
        n_checks++; if (pkt_cnt1 !== 16'd0) begin n_fail++; $display("FAIL single_cnt1: got %0d want 0", pkt_cnt1); end
    endtask

    task automatic test_stray();
        apply_reset();
        s0_data = 64'hDEAD_BEEF_0000_0001; s0_valid = 1'b1; s0_sof = 1'b0;
        #1;
        n_checks++; if ({s0_ready, trn_tsrc_rdy_n} !== 2'b01) begin n_fail++; $display("FAIL stray_offer: got %b want 01", {s0_ready, trn_tsrc_rdy_n}); end
        tick();
        clear_src();
        #1;
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b want 1", proto_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b want 0", busy); end
    endtask

    task automatic test_alternation();
        bit to;
        apply_reset();
        clear_all();
        for (int r = 0; r < 3; r++) begin
            add_pkt(0, 2, 1'b0);
            add_pkt(1, 2, 1'b0);
        end
        drive(200, 0, 0, to);
        build_model();
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL alt_timeout: got %b want 0", to); end
        n_checks++; if (link_log.size() != exp_link.size()) begin n_fail++; $display("FAIL alt_len: got %0d want %0d", link_log.size(), exp_link.size()); end
        for (int i = 0; i < link_log.size() && i < exp_link.size(); i++) begin
            n_checks++; if (link_log[i] !== exp_link[i]) begin n_fail++; $display("FAIL alt_beat%0d: got %h want %h", i, link_log[i], exp_link[i]); end
        end
        for (int i = 1; i < link_log.size(); i++) begin
            if (link_log[i].sof_n == 1'b0) begin
                n_checks++; if (link_cyc[i] - link_cyc[i-1] != 2) begin n_fail++; $display("FAIL alt_gap%0d: got %0d want 2", i, link_cyc[i] - link_cyc[i-1]); end
            end
        end
        n_checks++; if (pkt_cnt0 !== 16'd3) begin n_fail++; $display("FAIL alt_cnt0: got %0d want 3", pkt_cnt0); end
        n_checks++; if (pkt_cnt1 !== 16'd3) begin n_fail++; $display("FAIL alt_cnt1: got %0d want 3", pkt_cnt1); end
    endtask

    task automatic test_tbuf_av();
        bit to;
        int first;
        apply_reset();
        clear_all();
        trn_tbuf_av = 4'h0;
        add_pkt(1, 3, 1'b0);
        drive(10, 0, 0, to);
        n_checks++; if (link_log.size() != 0) begin n_fail++; $display("FAIL tbuf_held: got %0d beats want 0", link_log.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tbuf_busy: got %b want 0", busy); end
        trn_tbuf_av = 4'h1;
        drive(50, 0, 0, to);
        first = (link_cyc.size() > 0) ? link_cyc[0] : -1;
        n_checks++; if (first != 1) begin n_fail++; $display("FAIL tbuf_latency: got cycle %0d want 1", first); end
        n_checks++; if (link_log.size() != 3) begin n_fail++; $display("FAIL tbuf_len: got %0d want 3", link_log.size()); end
        n_checks++; if (pkt_cnt1 !== 16'd1) begin n_fail++; $display("FAIL tbuf_cnt1: got %0d want 1", pkt_cnt1); end
    endtask

    task automatic test_stall_half();
        bit to;
        apply_reset();
        clear_all();
        add_pkt(1, 5, 1'b1);
        drive(300, 40, 50, to);
        build_model();
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b want 0", to); end
        n_checks++; if (link_log.size() != exp_link.size()) begin n_fail++; $display("FAIL stall_len: got %0d want %0d", link_log.size(), exp_link.size()); end
        for (int i = 0; i < link_log.size() && i < exp_link.size(); i++) begin
            n_checks++; if (link_log[i] !== exp_link[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, link_log[i], exp_link[i]); end
        end
        n_checks++; if (pkt_cnt1 !== 16'd1) begin n_fail++; $display("FAIL stall_cnt1: got %0d want 1", pkt_cnt1); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", proto_err); end
    endtask

    task automatic test_max_beats();
        bit    to;
        beat_t b;
        int    dsc_at, last_at;
        logic  err_last;
        apply_reset();
        clear_all();
        for (int k = 0; k < 40; k++) begin
            b.data = {32'hCAFE_0000, 32'(k)}; b.sof = (k == 0); b.eof = 1'b0; b.half = 1'b0;
            q0.push_back(b);
        end
        drive(60, 0, 0, to);
        q0.delete();
        dsc_at   = (dsc_log.size() > 0) ? dsc_log[0] : -1;
        last_at  = (link_cyc.size() > 31) ? link_cyc[31] : -1;
        err_last = (err_log.size() > 31) ? err_log[31] : 1'bx;
        n_checks++; if (link_log.size() != 32) begin n_fail++; $display("FAIL max_beats: got %0d want 32", link_log.size()); end
        n_checks++; if (last_at != 32) begin n_fail++; $display("FAIL max_last_cycle: got %0d want 32", last_at); end
        n_checks++; if (err_last !== 1'b0) begin n_fail++; $display("FAIL max_err_early: got %b want 0", err_last); end
        n_checks++; if (dsc_log.size() != 1) begin n_fail++; $display("FAIL max_dsc_len: got %0d want 1", dsc_log.size()); end
        n_checks++; if (dsc_at != 33) begin n_fail++; $display("FAIL max_dsc_cycle: got %0d want 33", dsc_at); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL max_err: got %b want 1", proto_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL max_busy: got %b want 0", busy); end
        n_checks++; if (pkt_cnt0 !== 16'd0) begin n_fail++; $display("FAIL max_cnt0: got %0d want 0", pkt_cnt0); end
        n_checks++; if (trn_tsrc_dsc_n !== 1'b1) begin n_fail++; $display("FAIL max_dsc_after: got %b want 1", trn_tsrc_dsc_n); end
    endtask

    task automatic test_sof_mid();
        bit    to;
        beat_t b;
        apply_reset();
        clear_all();
        add_pkt(0, 3, 1'b0);
        b = q0[1]; b.sof = 1'b1; q0[1] = b; exp0[1] = b;
        drive(50, 0, 0, to);
        build_model();
        n_checks++; if (link_log.size() != exp_link.size()) begin n_fail++; $display("FAIL sofmid_len: got %0d want %0d", link_log.size(), exp_link.size()); end
        for (int i = 0; i < link_log.size() && i < exp_link.size(); i++) begin
            n_checks++; if (link_log[i] !== exp_link[i]) begin n_fail++; $display("FAIL sofmid_beat%0d: got %h want %h", i, link_log[i], exp_link[i]); end
        end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL sofmid_err: got %b want 1", proto_err); end
        n_checks++; if (pkt_cnt0 !== 16'd1) begin n_fail++; $display("FAIL sofmid_cnt0: got %0d want 1", pkt_cnt0); end
    endtask

    task automatic test_reset_mid();
        bit to;
        apply_reset();
        clear_all();
        s0_data = 64'hAAAA_0000_0000_0001; s0_sof = 1'b1; s0_eof = 1'b0; s0_valid = 1'b1;
        tick();
        tick();
        s0_data = 64'hAAAA_0000_0000_0002; s0_sof = 1'b0; reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n} !== 4'hF) begin n_fail++; $display("FAIL rmid_ctl: got %b want 1111", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n}); end
        n_checks++; if (trn_trem_n !== 8'h00) begin n_fail++; $display("FAIL rmid_trem: got %h want 00", trn_trem_n); end
        n_checks++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_ready: got %b want 00", {s0_ready, s1_ready}); end
        n_checks++; if (pkt_cnt0 !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt0: got %0d want 0", pkt_cnt0); end
        reset = 1'b0;
        clear_src();
        add_pkt(0, 3, 1'b1);
        drive(50, 0, 0, to);
        build_model();
        n_checks++; if (link_log.size() != exp_link.size()) begin n_fail++; $display("FAIL rmid_len: got %0d want %0d", link_log.size(), exp_link.size()); end
        for (int i = 0; i < link_log.size() && i < exp_link.size(); i++) begin
            n_checks++; if (link_log[i] !== exp_link[i]) begin n_fail++; $display("FAIL rmid_beat%0d: got %h want %h", i, link_log[i], exp_link[i]); end
        end
        n_checks++; if (pkt_cnt0 !== 16'd1) begin n_fail++; $display("FAIL rmid_cnt_after: got %0d want 1", pkt_cnt0); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", proto_err); end
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            clear_all();
            for (int p = 0; p < 6; p++) begin
                add_pkt(0, int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
                add_pkt(1, int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
            end
            drive(3000, 30, 30, to);
            build_model();
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b want 0", it, to); end
            n_checks++; if (link_log.size() != exp_link.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", it, link_log.size(), exp_link.size()); end
            for (int i = 0; i < link_log.size() && i < exp_link.size(); i++) begin
                n_checks++; if (link_log[i] !== exp_link[i]) begin n_fail++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, link_log[i], exp_link[i]); end
            end
            n_checks++; if (pkt_cnt0 !== 16'd6) begin n_fail++; $display("FAIL rand%0d_cnt0: got %0d want 6", it, pkt_cnt0); end
            n_checks++; if (pkt_cnt1 !== 16'd6) begin n_fail++; $display("FAIL rand%0d_cnt1: got %0d want 6", it, pkt_cnt1); end
            n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_err: got %b want 0", it, proto_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_src();
        trn_tdst_rdy_n = 1'b0;
        trn_tbuf_av    = 4'hF;
        test_reset();
        test_single_tlp();
        test_stray();
        test_alternation();
        test_tbuf_av();
        test_stall_half();
        test_max_beats();
        test_sof_mid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
